trap_sequencer: RTL and testbench

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

---
 rtl/trap_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_trap_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : trap_sequencer
// Purpose  : Sequences trap entry (exception/interrupt) and trap return
//            (MRET/SRET) for the WB stage. A trap entry writes xEPC, xCAUSE,
//            xTVAL and mstatus one CSR per cycle, then redirects fetch to the
//            target trap vector. A trap return rewrites mstatus, then
//            redirects fetch to xEPC. The pipeline is stalled throughout.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            except_i, epc_i,
//            ecause_i, etval_i        - committed exception record from WB
//            mret_i, sret_i           - committed trap return in WB
//            priv_i                   - current privilege level
//            mstatus_i .. mideleg_i   - CSR read values
//            csr_we_o/waddr_o/wdata_o - single CSR write port
//            stall_o, flush_o         - pipeline freeze / kill
//            redirect_o/redirect_pc_o - fetch redirect
//            priv_we_o, priv_o        - privilege-register update
// Revision : 1.0 - initial release
// ============================================================================
module trap_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        except_i,
  input  logic [63:0] epc_i,
  input  logic [63:0] ecause_i,
  input  logic [63:0] etval_i,
  input  logic        mret_i,
  input  logic        sret_i,
  input  logic [1:0]  priv_i,
  input  logic [63:0] mstatus_i,
  input  logic [63:0] mtvec_i,
  input  logic [63:0] stvec_i,
  input  logic [63:0] mepc_i,
  input  logic [63:0] sepc_i,
  input  logic [63:0] medeleg_i,
  input  logic [63:0] mideleg_i,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [63:0] csr_wdata_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [63:0] redirect_pc_o,
  output logic        priv_we_o,
  output logic [1:0]  priv_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_EPC    = 3'd1,
    W_CAUSE  = 3'd2,
    W_TVAL   = 3'd3,
    W_STATUS = 3'd4,
    REDIRECT = 3'd5
  } state_e;

  localparam logic [1:0] KIND_EXC  = 2'd0;
  localparam logic [1:0] KIND_MRET = 2'd1;
  localparam logic [1:0] KIND_SRET = 2'd2;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;

  state_e      state_q, state_d;
  logic [1:0]  kind_q, kind_d;
  logic [63:0] epc_q, epc_d;
  logic [63:0] cause_q, cause_d;
  logic [63:0] tval_q, tval_d;
  logic [1:0]  priv_q, priv_d;       // privilege at trap entry
  logic        tgt_s_q, tgt_s_d;     // 1: trap handled in S-mode
  logic [1:0]  ret_priv_q, ret_priv_d; // privilege delivered on redirect

  logic        w_deleg;
  logic [63:0] w_status_new;
  logic        w_unused_tvec_mode;

  // Vectors are used in direct mode only; the MODE field is ignored.
  assign w_unused_tvec_mode = ^{mtvec_i[1:0], stvec_i[1:0]};

  // Delegation bit: interrupts consult mideleg, exceptions medeleg.
  assign w_deleg = ecause_i[63] ? mideleg_i[ecause_i[5:0]] : medeleg_i[ecause_i[5:0]];

  // New mstatus value, built from the live mstatus read in W_STATUS.
  always_comb begin
    w_status_new = mstatus_i;
    case (kind_q)
      KIND_EXC: begin
        if (tgt_s_q) begin
          w_status_new[5] = mstatus_i[1];
          w_status_new[1] = 1'b0;
          w_status_new[8] = priv_q[0];
        end else begin
          w_status_new[7]     = mstatus_i[3];
          w_status_new[3]     = 1'b0;
          w_status_new[12:11] = priv_q;
        end
      end
      KIND_MRET: begin
        w_status_new[3]     = mstatus_i[7];
        w_status_new[7]     = 1'b1;
        w_status_new[12:11] = 2'b00;
      end
      KIND_SRET: begin
        w_status_new[1] = mstatus_i[5];
        w_status_new[5] = 1'b1;
        w_status_new[8] = 1'b0;
      end
      default: w_status_new = mstatus_i;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    epc_d         = epc_q;
    cause_d       = cause_q;
    tval_d        = tval_q;
    priv_d        = priv_q;
    tgt_s_d       = tgt_s_q;
    ret_priv_d    = ret_priv_q;
    csr_we_o      = 1'b0;
    csr_waddr_o   = 12'h000;
    csr_wdata_o   = 64'h0;
    stall_o       = 1'b1;
    flush_o       = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = 64'h0;
    priv_we_o     = 1'b0;
    priv_o        = 2'b00;
    case (state_q)
      IDLE: begin
        stall_o = 1'b0;
        // Exception wins over a trap return presented in the same cycle.
        if (except_i) begin
          kind_d  = KIND_EXC;
          epc_d   = epc_i;
          cause_d = ecause_i;
          tval_d  = etval_i;
          priv_d  = priv_i;
          tgt_s_d = (priv_i != 2'b11) && w_deleg;
          state_d = W_EPC;
        end else if (mret_i) begin
          kind_d  = KIND_MRET;
          tgt_s_d = 1'b0;
          state_d = W_STATUS;
        end else if (sret_i) begin
          kind_d  = KIND_SRET;
          tgt_s_d = 1'b1;
          state_d = W_STATUS;
        end
      end
      W_EPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = tgt_s_q ? 12'h141 : 12'h341;
        csr_wdata_o = epc_q;
        state_d     = W_CAUSE;
      end
      W_CAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = tgt_s_q ? 12'h142 : 12'h342;
        csr_wdata_o = cause_q;
        state_d     = W_TVAL;
      end
      W_TVAL: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = tgt_s_q ? 12'h143 : 12'h343;
        csr_wdata_o = tval_q;
        state_d     = W_STATUS;
      end
      W_STATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = w_status_new;
        // Capture the return privilege now: mstatus is rewritten this cycle,
        // so the old MPP/SPP is no longer visible in REDIRECT.
        case (kind_q)
          KIND_MRET: ret_priv_d = mstatus_i[12:11];
          KIND_SRET: ret_priv_d = {1'b0, mstatus_i[8]};
          default:   ret_priv_d = tgt_s_q ? 2'b01 : 2'b11;
        endcase
        state_d = REDIRECT;
      end
      REDIRECT: begin
        redirect_o = 1'b1;
        flush_o    = 1'b1;
        priv_we_o  = 1'b1;
        priv_o     = ret_priv_q;
        case (kind_q)
          KIND_MRET: redirect_pc_o = mepc_i;
          KIND_SRET: redirect_pc_o = sepc_i;
          default:   redirect_pc_o = tgt_s_q ? {stvec_i[63:2], 2'b00}
                                             : {mtvec_i[63:2], 2'b00};
        endcase
        state_d = IDLE;
      end
      default: begin
        stall_o = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      kind_q     <= KIND_EXC;
      epc_q      <= 64'h0;
      cause_q    <= 64'h0;
      tval_q     <= 64'h0;
      priv_q     <= 2'b00;
      tgt_s_q    <= 1'b0;
      ret_priv_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
      tval_q     <= tval_d;
      priv_q     <= priv_d;
      tgt_s_q    <= tgt_s_d;
      ret_priv_q <= ret_priv_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_sequencer
// Purpose  : Scoreboard bench for trap_sequencer. Stimulus pushes the
//            expected CSR writes and redirect (with their cycle numbers) into
//            a queue; an independent monitor pops and compares whenever the
//            DUT presents a write or redirect.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        except_i, mret_i, sret_i;
  logic [63:0] epc_i, ecause_i, etval_i;
  logic [1:0]  priv_i;
  logic [63:0] mstatus_i, mtvec_i, stvec_i, mepc_i, sepc_i, medeleg_i, mideleg_i;
  logic        csr_we_o, stall_o, flush_o, redirect_o, priv_we_o;
  logic [11:0] csr_waddr_o;
  logic [63:0] csr_wdata_o, redirect_pc_o;
  logic [1:0]  priv_o;

  trap_sequencer dut (
    .clk(clk), .rst(rst),
    .except_i(except_i), .epc_i(epc_i), .ecause_i(ecause_i), .etval_i(etval_i),
    .mret_i(mret_i), .sret_i(sret_i), .priv_i(priv_i),
    .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .stvec_i(stvec_i),
    .mepc_i(mepc_i), .sepc_i(sepc_i), .medeleg_i(medeleg_i), .mideleg_i(mideleg_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .stall_o(stall_o), .flush_o(flush_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .priv_we_o(priv_we_o), .priv_o(priv_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          redir;
    logic [11:0] addr;
    logic [63:0] data;
    logic [1:0]  priv;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   busy_last = -1;   // last cycle in which the DUT is expected busy
  bit   mon_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(int c, bit r, logic [11:0] a, logic [63:0] d, logic [1:0] p);
    exp_t x;
    x.cyc = c; x.redir = r; x.addr = a; x.data = d; x.priv = p;
    return x;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      chk("stall", 64'(stall_o), 64'(cyc <= busy_last));
      if (csr_we_o || redirect_o) begin
        if (q.size() == 0) begin
          chk("unexpected_event", 64'({csr_we_o, redirect_o}), 64'd0);
        end else begin
          e = q.pop_front();
          chk("event_cycle", 64'(cyc), 64'(e.cyc));
          chk("event_is_redirect", 64'(redirect_o), 64'(e.redir));
          if (e.redir) begin
            chk("redirect_pc", redirect_pc_o, e.data);
            chk("redirect_priv", 64'(priv_o), 64'(e.priv));
            chk("redirect_flush", 64'(flush_o), 64'd1);
            chk("redirect_priv_we", 64'(priv_we_o), 64'd1);
            chk("redirect_csr_we", 64'(csr_we_o), 64'd0);
          end else begin
            chk("csr_waddr", 64'(csr_waddr_o), 64'(e.addr));
            chk("csr_wdata", csr_wdata_o, e.data);
            chk("write_flush", 64'(flush_o), 64'd0);
            chk("write_priv_we", 64'(priv_we_o), 64'd0);
          end
        end
      end else begin
        chk("quiet_waddr", 64'(csr_waddr_o), 64'd0);
        chk("quiet_wdata", csr_wdata_o, 64'd0);
        chk("quiet_flush", 64'(flush_o), 64'd0);
        chk("quiet_priv_we", 64'(priv_we_o), 64'd0);
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          chk("missing_event", 64'(q[0].cyc), 64'hFFFF_FFFF_FFFF_FFFF);
          void'(q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus / reference model ----------------
  task automatic clr_events();
    except_i = 1'b0; mret_i = 1'b0; sret_i = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc <= busy_last) @(negedge clk);
  endtask

  // Trap entry: target S only if below M and the delegation bit is set.
  task automatic do_exc(input logic [63:0] epc, input logic [63:0] cause, input logic [63:0] tval);
    bit          s;
    logic [11:0] base;
    logic [63:0] ms;
    int          c;
    wait_idle();
    c = cyc;
    epc_i = epc; ecause_i = cause; etval_i = tval; except_i = 1'b1;
    s = (priv_i != 2'b11) &&
        (cause[63] ? mideleg_i[cause[5:0]] : medeleg_i[cause[5:0]]);
    base = s ? 12'h100 : 12'h300;
    ms = mstatus_i;
    if (s) begin ms[5] = ms[1]; ms[1] = 1'b0; ms[8] = priv_i[0]; end
    else   begin ms[7] = ms[3]; ms[3] = 1'b0; ms[12:11] = priv_i; end
    q.push_back(mk(c + 1, 1'b0, base + 12'h41, epc, 2'b00));
    q.push_back(mk(c + 2, 1'b0, base + 12'h42, cause, 2'b00));
    q.push_back(mk(c + 3, 1'b0, base + 12'h43, tval, 2'b00));
    q.push_back(mk(c + 4, 1'b0, 12'h300, ms, 2'b00));
    q.push_back(mk(c + 5, 1'b1, 12'h000, (s ? stvec_i : mtvec_i) & ~64'h3, s ? 2'b01 : 2'b11));
    busy_last = c + 5;
    @(negedge clk);
    clr_events();
  endtask

  task automatic do_ret(input bit is_m);
    logic [63:0] ms;
    int          c;
    wait_idle();
    c = cyc;
    ms = mstatus_i;
    if (is_m) begin
      mret_i = 1'b1;
      ms[3] = ms[7]; ms[7] = 1'b1; ms[12:11] = 2'b00;
      q.push_back(mk(c + 1, 1'b0, 12'h300, ms, 2'b00));
      q.push_back(mk(c + 2, 1'b1, 12'h000, mepc_i, mstatus_i[12:11]));
    end else begin
      sret_i = 1'b1;
      ms[1] = ms[5]; ms[5] = 1'b1; ms[8] = 1'b0;
      q.push_back(mk(c + 1, 1'b0, 12'h300, ms, 2'b00));
      q.push_back(mk(c + 2, 1'b1, 12'h000, sepc_i, {1'b0, mstatus_i[8]}));
    end
    busy_last = c + 2;
    @(negedge clk);
    clr_events();
  endtask

  // Random events while busy must all be ignored.
  task automatic drain();
    while (cyc <= busy_last) begin
      except_i = 1'($urandom_range(0, 1));
      mret_i   = 1'($urandom_range(0, 1));
      sret_i   = 1'($urandom_range(0, 1));
      epc_i    = rnd64();
      ecause_i = rnd64();
      @(negedge clk);
    end
    clr_events();
  endtask

  // Reset for one cycle with an event presented alongside (to be discarded).
  task automatic do_rst();
    int c;
    c = cyc;
    rst = 1'b1;
    except_i = 1'b1; mret_i = 1'b1;
    while (q.size() > 0 && q[q.size() - 1].cyc > c) void'(q.pop_back());
    if (busy_last > c) busy_last = c;
    @(negedge clk);
    rst = 1'b0;
    clr_events();
  endtask

  task automatic rand_csrs();
    case ($urandom_range(0, 2))
      0:       priv_i = 2'b00;
      1:       priv_i = 2'b01;
      default: priv_i = 2'b11;
    endcase
    mstatus_i = rnd64(); mtvec_i = rnd64(); stvec_i = rnd64();
    mepc_i = rnd64(); sepc_i = rnd64();
    medeleg_i = rnd64(); mideleg_i = rnd64();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clr_events();
    epc_i = '0; ecause_i = '0; etval_i = '0; priv_i = 2'b00;
    mstatus_i = '0; mtvec_i = '0; stvec_i = '0; mepc_i = '0; sepc_i = '0;
    medeleg_i = '0; mideleg_i = '0;
    @(negedge clk);
    mon_en = 1'b1;            // reset-state outputs checked from here on
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // U-mode illegal instruction, not delegated -> M
    priv_i = 2'b00; mtvec_i = 64'h8000_0100; medeleg_i = '0; mideleg_i = '0;
    mstatus_i = 64'h8;
    do_exc(64'h1000, 64'd2, 64'hDEAD_BEEF);
    drain();

    // U-mode ecall delegated -> S, vector MODE bits dropped
    stvec_i = 64'h9000_0003; medeleg_i = 64'h100; mstatus_i = 64'h2;
    do_exc(64'h1004, 64'd8, 64'h55);
    drain();

    // M-mode never delegates
    priv_i = 2'b11; medeleg_i = '1; mideleg_i = '1;
    do_exc(64'h1008, 64'd5, 64'h0);
    drain();

    // Delegated S-mode interrupt (cause bit 63)
    priv_i = 2'b01; medeleg_i = '0; mideleg_i = 64'h20;
    do_exc(64'h100C, 64'h8000_0000_0000_0005, 64'h0);
    drain();

    // MRET with MPP=01, MPIE=1
    priv_i = 2'b11; mstatus_i = 64'h880; mepc_i = 64'h2000;
    do_ret(1'b1);
    drain();

    // SRET with SPP=1, SPIE=0, SIE=1
    priv_i = 2'b01; mstatus_i = 64'h102; sepc_i = 64'h3000;
    do_ret(1'b0);
    drain();

    // Exception and MRET together, then a second exception in W_CAUSE
    priv_i = 2'b00; medeleg_i = '0; mideleg_i = '0; mstatus_i = 64'h8;
    mret_i = 1'b1;
    do_exc(64'h4000, 64'd3, 64'h77);
    @(negedge clk);
    except_i = 1'b1; epc_i = 64'hBAD; ecause_i = 64'd9;
    @(negedge clk);
    clr_events();
    drain();

    // Reset during W_TVAL aborts the sequence
    do_exc(64'h5000, 64'd4, 64'h88);
    @(negedge clk);
    @(negedge clk);
    do_rst();
    repeat (2) @(negedge clk);

    // Reset while idle with an event present
    do_rst();
    repeat (2) @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      int act;
      rand_csrs();
      act = int'($urandom_range(0, 19));
      if (act < 12) begin
        do_exc(rnd64(), rnd64(), rnd64());
        drain();
      end else if (act < 15) begin
        do_ret(1'b1);
        drain();
      end else if (act < 18) begin
        do_ret(1'b0);
        drain();
      end else begin
        do_exc(rnd64(), rnd64(), rnd64());
        repeat ($urandom_range(0, 4)) @(negedge clk);
        do_rst();
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
